// File: rtl/divmod_seq.sv
// -----------------------------------------------------------------------------
// divmod_seq
//   Sequential restoring shift-subtract divider. Produces one quotient bit per
//   clock, so latency is fixed at WIDTH+1 cycles for a nonzero divisor and two
//   edges (accept + finish) for a zero divisor. Optional two's-complement mode
//   works on magnitudes internally and fixes up signs in the finish state
//   (truncation toward zero, remainder takes the dividend's sign).
//
// Parameters
//   WIDTH   operand/result width in bits (>= 2)
//   SIGNED  0 = unsigned operands, 1 = two's-complement operands
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only while idle
//   dividend     numerator, captured on the accepting edge
//   divisor      denominator, captured on the accepting edge
//   busy         high while a division is in progress (RUN or FIN)
//   done         one-cycle completion pulse
//   quotient     registered quotient of the last completed operation
//   remainder    registered remainder of the last completed operation
//   div_by_zero  registered divide-by-zero flag of the last completed operation
// -----------------------------------------------------------------------------
module divmod_seq #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   prem_q, prem_d;      // partial remainder
    logic [WIDTH-1:0]   dvd_q, dvd_d;        // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   dsr_q, dsr_d;        // divisor magnitude
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dbz_pend_q, dbz_pend_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               dbz_q, dbz_d;
    logic               done_q, done_d;

    // Trial subtraction: the shifted partial remainder needs WIDTH+1 bits,
    // and one more bit holds the borrow.
    logic [WIDTH:0]     prem_sh;
    logic [WIDTH+1:0]   trial;
    logic               borrow;

    assign prem_sh = {prem_q, dvd_q[WIDTH-1]};
    assign trial   = {1'b0, prem_sh} - {2'b00, dsr_q};
    assign borrow  = trial[WIDTH+1];

    // Whichever branch is kept is always smaller than the divisor, so bit
    // WIDTH of both candidates is zero and is dropped on purpose.
    logic unused_top_bits;
    assign unused_top_bits = prem_sh[WIDTH] ^ trial[WIDTH];

    // |x| in two's-complement mode; the most negative value maps to the
    // unsigned 2^(WIDTH-1), which still fits in WIDTH bits.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return (SIGNED && x[WIDTH-1]) ? (-x) : x;
    endfunction

    always_comb begin
        // NOTE: every variable gets a default here first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        prem_d      = prem_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        dbz_pend_d  = dbz_pend_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        // Preload the result registers so FIN needs no
                        // special path: all-ones quotient, raw dividend.
                        dvd_d      = '1;
                        prem_d     = dividend;
                        neg_quo_d  = 1'b0;
                        neg_rem_d  = 1'b0;
                        dbz_pend_d = 1'b1;
                        state_d    = S_FIN;
                    end else begin
                        dvd_d      = mag(dividend);
                        dsr_d      = mag(divisor);
                        prem_d     = '0;
                        cnt_d      = CNT_W'(WIDTH - 1);
                        neg_quo_d  = SIGNED & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_rem_d  = SIGNED & dividend[WIDTH-1];
                        dbz_pend_d = 1'b0;
                        state_d    = S_RUN;
                    end
                end
            end

            S_RUN: begin
                prem_d = borrow ? prem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
                dvd_d  = {dvd_q[WIDTH-2:0], ~borrow};
                if (cnt_q == '0) begin
                    state_d = S_FIN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_FIN: begin
                // MIN / -1 needs no special case: the magnitude quotient is
                // 2^(WIDTH-1), signs agree, so the bit pattern is MIN itself.
                quotient_d  = neg_quo_q ? (-dvd_q) : dvd_q;
                remainder_d = neg_rem_q ? (-prem_q) : prem_q;
                dbz_d       = dbz_pend_q;
                done_d      = 1'b1;
                state_d     = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            prem_q      <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dbz_pend_q  <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prem_q      <= prem_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            dbz_pend_q  <= dbz_pend_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divmod_seq.sv
// -----------------------------------------------------------------------------
// tb_divmod_seq
//   Two divider instances share clock and reset: a 32-bit unsigned one and an
//   8-bit signed one. Drivers push expected results (value, flag and the cycle
//   the done pulse must appear in) into per-instance queues; independent
//   monitors pop and compare whenever done is seen and watch busy in between.
// -----------------------------------------------------------------------------
module tb_divmod_seq;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          acc_cyc;   // cycle count after the accepting edge
        int          exp_cyc;   // cycle count in which done must be high
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        start32, busy32, done32, dbz32;
    logic [31:0] dvd32, dsr32, q32, r32;

    logic        start8, busy8, done8, dbz8;
    logic [7:0]  dvd8, dsr8, q8, r8;

    exp_t        sb32[$];
    exp_t        sb8[$];
    int          cyc;
    int          n_vec;
    int          n_checks;
    int          miscompares;

    divmod_seq #(.WIDTH(32), .SIGNED(1'b0)) u32 (
        .clk(clk), .rst_n(rst_n), .start(start32),
        .dividend(dvd32), .divisor(dsr32),
        .busy(busy32), .done(done32),
        .quotient(q32), .remainder(r32), .div_by_zero(dbz32)
    );

    divmod_seq #(.WIDTH(8), .SIGNED(1'b1)) u8s (
        .clk(clk), .rst_n(rst_n), .start(start8),
        .dividend(dvd8), .divisor(dsr8),
        .busy(busy8), .done(done8),
        .quotient(q8), .remainder(r8), .div_by_zero(dbz8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference models: plain division from the operation rules.
    function automatic exp_t model32(input logic [31:0] a, input logic [31:0] b, input int acc);
        exp_t e;
        e.acc_cyc = acc;
        if (b == 0) begin
            e.q = 32'hFFFF_FFFF; e.r = a; e.dbz = 1'b1; e.exp_cyc = acc + 1;
        end else begin
            e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.exp_cyc = acc + 33;
        end
        return e;
    endfunction

    function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input int acc);
        exp_t e;
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        e.acc_cyc = acc;
        if (b == 0) begin
            e.q = 32'h0000_00FF; e.r = {24'b0, a}; e.dbz = 1'b1; e.exp_cyc = acc + 1;
        end else begin
            // Integer division truncates toward zero; -128/-1 = 128 wraps to 0x80.
            e.q = {24'b0, 8'(sa / sb)}; e.r = {24'b0, 8'(sa % sb)};
            e.dbz = 1'b0; e.exp_cyc = acc + 9;
        end
        return e;
    endfunction

    // Monitors
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (sb32.size() != 0 && cyc >= sb32[0].acc_cyc && cyc < sb32[0].exp_cyc)
                check("u32 busy during op", {31'b0, busy32}, 32'd1);
            if (done32) begin
                if (sb32.size() == 0) begin
                    check("u32 unexpected done", {31'b0, done32}, 32'd0);
                end else begin
                    e = sb32.pop_front();
                    check("u32 quotient", q32, e.q);
                    check("u32 remainder", r32, e.r);
                    check("u32 div_by_zero", {31'b0, dbz32}, {31'b0, e.dbz});
                    check("u32 done cycle", cyc, e.exp_cyc);
                    check("u32 busy in done cycle", {31'b0, busy32}, 32'd0);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (sb8.size() != 0 && cyc >= sb8[0].acc_cyc && cyc < sb8[0].exp_cyc)
                check("s8 busy during op", {31'b0, busy8}, 32'd1);
            if (done8) begin
                if (sb8.size() == 0) begin
                    check("s8 unexpected done", {31'b0, done8}, 32'd0);
                end else begin
                    e = sb8.pop_front();
                    check("s8 quotient", {24'b0, q8}, e.q);
                    check("s8 remainder", {24'b0, r8}, e.r);
                    check("s8 div_by_zero", {31'b0, dbz8}, {31'b0, e.dbz});
                    check("s8 done cycle", cyc, e.exp_cyc);
                    check("s8 busy in done cycle", {31'b0, busy8}, 32'd0);
                end
            end
        end
    end

    // Drivers: start is high for exactly one edge; operands are scrambled
    // afterwards to show they were captured. Return at the negedge after the
    // accepting edge.
    task automatic push32(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start32 = 1'b1; dvd32 = a; dsr32 = b;
        sb32.push_back(model32(a, b, cyc + 1));
        n_vec++;
        @(negedge clk);
        start32 = 1'b0; dvd32 = $urandom; dsr32 = $urandom;
    endtask

    task automatic push8(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start8 = 1'b1; dvd8 = a; dsr8 = b;
        sb8.push_back(model8(a, b, cyc + 1));
        n_vec++;
        @(negedge clk);
        start8 = 1'b0; dvd8 = 8'($urandom); dsr8 = 8'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (sb32.size() != 0 || sb8.size() != 0); i++)
            @(negedge clk);
        if (sb32.size() != 0) begin
            check("u32 done timeout", 32'(sb32.size()), 32'd0);
            sb32.delete();
        end
        if (sb8.size() != 0) begin
            check("s8 done timeout", 32'(sb8.size()), 32'd0);
            sb8.delete();
        end
    endtask

    task automatic check_all_reset();
        check("u32 reset quotient", q32, 32'd0);
        check("u32 reset remainder", r32, 32'd0);
        check("u32 reset div_by_zero", {31'b0, dbz32}, 32'd0);
        check("u32 reset busy", {31'b0, busy32}, 32'd0);
        check("u32 reset done", {31'b0, done32}, 32'd0);
        check("s8 reset quotient", {24'b0, q8}, 32'd0);
        check("s8 reset remainder", {24'b0, r8}, 32'd0);
        check("s8 reset div_by_zero", {31'b0, dbz8}, 32'd0);
        check("s8 reset busy", {31'b0, busy8}, 32'd0);
        check("s8 reset done", {31'b0, done8}, 32'd0);
    endtask

    // Watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, b;
        logic [7:0]  a8, b8;
        int          sel;

        n_vec = 0; n_checks = 0; miscompares = 0;
        start32 = 1'b0; dvd32 = '0; dsr32 = '0;
        start8  = 1'b0; dvd8  = '0; dsr8  = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_all_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed unsigned cases, including divide by zero and its clearing
        push32(32'd100, 32'd7);          drain();
        push32(32'hFFFF_FFFF, 32'd1);    drain();
        push32(32'd5, 32'd9);            drain();
        push32(32'd1234, 32'd0);         drain();
        push32(32'd100, 32'd7);          drain();

        // Directed signed cases
        push8(8'hF9, 8'h02);             drain();   // -7 / 2
        push8(8'h07, 8'hFE);             drain();   // 7 / -2
        push8(8'h80, 8'hFF);             drain();   // -128 / -1
        push8(8'h80, 8'h00);             drain();   // divide by zero, raw dividend back
        push8(8'h80, 8'h01);             drain();   // -128 / 1

        // start pulsed mid-run must be ignored
        push32(32'd50, 32'd5);
        repeat (8) @(negedge clk);
        start32 = 1'b1; dvd32 = 32'd9; dsr32 = 32'd3;
        @(negedge clk);
        start32 = 1'b0;
        drain();

        // Back-to-back: start held through FIN and done cycles
        push32(32'd100, 32'd7);
        repeat (32) @(negedge clk);      // FIN cycle: start here is ignored
        start32 = 1'b1; dvd32 = 32'd81; dsr32 = 32'd9;
        @(negedge clk);                  // done cycle: next edge accepts
        sb32.push_back(model32(32'd81, 32'd9, cyc + 1));
        n_vec++;
        @(negedge clk);
        start32 = 1'b0;
        drain();

        // Reset during iteration 10 discards the operation
        push32(32'd100, 32'd7);
        repeat (10) @(negedge clk);
        #3;
        sb32.delete();
        rst_n = 1'b0;
        #1 check_all_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        push32(32'd100, 32'd7);          drain();

        // Randomised unsigned
        for (int i = 0; i < 40; i++) begin
            a   = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       b = 32'd0;
                1:       b = 32'd1;
                2:       b = $urandom_range(1, 15);
                3:       b = a;
                4:       b = 32'hFFFF_FFFF;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if (sel == 5) a = $urandom_range(0, 3);
            push32(a, b);
            drain();
        end

        // Randomised signed
        for (int i = 0; i < 60; i++) begin
            a8  = 8'($urandom);
            sel = $urandom_range(0, 7);
            case (sel)
                0:       b8 = 8'h00;
                1:       b8 = 8'hFF;
                2:       b8 = 8'h80;
                3:       b8 = 8'h01;
                default: b8 = 8'($urandom);
            endcase
            if (sel == 4) a8 = 8'h80;
            push8(a8, b8);
            drain();
        end

        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end

endmodule
